// File: rtl/rx_frame_receiver_if.sv
// Serial receiver bundle: line input plus the deserialised word and status pulses.
// err_count is present only when RX_ERR_CNT_EN is defined.
interface rx_frame_receiver_if #(
  parameter int BIT_LEN = 7
);
  logic               channel_in;
  logic [BIT_LEN-1:0] data_out;
  logic               valid;
  logic               parity_err;
  logic               frame_err;
  logic               busy;
`ifdef RX_ERR_CNT_EN
  logic [7:0]         err_count;

  modport master (
    input  channel_in,
    output data_out, valid, parity_err, frame_err, busy, err_count
  );
  modport slave (
    output channel_in,
    input  data_out, valid, parity_err, frame_err, busy, err_count
  );
`else
  modport master (
    input  channel_in,
    output data_out, valid, parity_err, frame_err, busy
  );
  modport slave (
    output channel_in,
    input  data_out, valid, parity_err, frame_err, busy
  );
`endif
endinterface

// File: rtl/rx_frame_receiver.sv
// Same-clock serial frame receiver: start | BIT_LEN data (LSB first) | even parity | stop.
// Optional saturating error counter enabled by RX_ERR_CNT_EN.
module rx_frame_receiver #(
  parameter int BIT_LEN = 7
) (
  input logic                 clk,
  input logic                 rst,
  rx_frame_receiver_if.master bus
);
  localparam int CNT_W = $clog2(BIT_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIT_LEN - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  function automatic logic even_parity(input logic [BIT_LEN-1:0] word);
    return ^word;
  endfunction

  state_t             state_r, state_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic [BIT_LEN-1:0] shift_r, shift_s;
  logic               p_rx_r, p_rx_s;
  logic [BIT_LEN-1:0] data_r, data_s;
  logic               valid_r, valid_s;
  logic               parity_err_r, parity_err_s;
  logic               frame_err_r, frame_err_s;
  logic               busy_r, busy_s;
`ifdef RX_ERR_CNT_EN
  logic [7:0]         err_cnt_r, err_cnt_s;
`endif

  // Next-state, datapath and registered-output computation
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    shift_s      = shift_r;
    p_rx_s       = p_rx_r;
    data_s       = data_r;
    valid_s      = 1'b0;
    parity_err_s = 1'b0;
    frame_err_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.channel_in) begin
          state_s = DATA;
          cnt_s   = {CNT_W{1'b0}};
        end else begin
          state_s = IDLE;
        end
      end
      DATA: begin
        for (int i = 0; i < BIT_LEN; i++) begin
          if (cnt_r == CNT_W'(i)) begin
            shift_s[i] = bus.channel_in;
          end else begin
            shift_s[i] = shift_r[i];
          end
        end
        cnt_s = cnt_r + CNT_W'(1);
        if (cnt_r == LAST_CNT) begin
          state_s = PARITY;
        end else begin
          state_s = DATA;
        end
      end
      PARITY: begin
        p_rx_s  = bus.channel_in;
        state_s = STOP;
      end
      STOP: begin
        // Framing takes precedence: parity of a mis-framed word is meaningless
        state_s = IDLE;
        if (!bus.channel_in) begin
          frame_err_s = 1'b1;
        end else if (p_rx_r != even_parity(shift_r)) begin
          parity_err_s = 1'b1;
        end else begin
          data_s  = shift_r;
          valid_s = 1'b1;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    busy_s = (state_s != IDLE);
`ifdef RX_ERR_CNT_EN
    if ((parity_err_s || frame_err_s) && (err_cnt_r != 8'hFF)) begin
      err_cnt_s = err_cnt_r + 8'd1;
    end else begin
      err_cnt_s = err_cnt_r;
    end
`endif
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      cnt_r        <= {CNT_W{1'b0}};
      shift_r      <= {BIT_LEN{1'b0}};
      p_rx_r       <= 1'b0;
      data_r       <= {BIT_LEN{1'b0}};
      valid_r      <= 1'b0;
      parity_err_r <= 1'b0;
      frame_err_r  <= 1'b0;
      busy_r       <= 1'b0;
`ifdef RX_ERR_CNT_EN
      err_cnt_r    <= 8'h00;
`endif
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      shift_r      <= shift_s;
      p_rx_r       <= p_rx_s;
      data_r       <= data_s;
      valid_r      <= valid_s;
      parity_err_r <= parity_err_s;
      frame_err_r  <= frame_err_s;
      busy_r       <= busy_s;
`ifdef RX_ERR_CNT_EN
      err_cnt_r    <= err_cnt_s;
`endif
    end
  end

  assign bus.data_out   = data_r;
  assign bus.valid      = valid_r;
  assign bus.parity_err = parity_err_r;
  assign bus.frame_err  = frame_err_r;
  assign bus.busy       = busy_r;
`ifdef RX_ERR_CNT_EN
  assign bus.err_count  = err_cnt_r;
`endif
endmodule
